// File: rtl/tb_clkmon.sv
// Clock/strobe monitor: measures rise-to-rise period and high time of mon in clk cycles,
// checks period against [MIN_PERIOD, MAX_PERIOD], tracks lock and reports errors.
module tb_clkmon #(
   parameter int unsigned CW         = 16,
   parameter int unsigned MIN_PERIOD = 2,
   parameter int unsigned MAX_PERIOD = 16,
   parameter int unsigned LOCK_EDGES = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mon,
   output logic          locked,
   output logic [CW-1:0] period,
   output logic          period_vld,
   output logic [CW-1:0] high_time,
   output logic          err,
   output logic [1:0]    err_cause,
   output logic [CW-1:0] err_count,
   output logic [CW-1:0] edge_count
);

   typedef enum logic [1:0] {StIdle, StAcq, StLock} state_e;

   localparam logic [CW-1:0] MinP  = CW'(MIN_PERIOD);
   localparam logic [CW-1:0] MaxP  = CW'(MAX_PERIOD);
   localparam logic [CW-1:0] MaxP1 = CW'(MAX_PERIOD + 1);
   localparam logic [CW-1:0] LockN = CW'(LOCK_EDGES);
   localparam logic [CW-1:0] One   = CW'(1);

   state_e        state_q, state_d;
   logic          mon_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] good_q, good_d;
   logic [CW-1:0] period_q, period_d;
   logic          period_vld_q, period_vld_d;
   logic [CW-1:0] high_time_q, high_time_d;
   logic          err_q, err_d;
   logic [1:0]    err_cause_q, err_cause_d;
   logic [CW-1:0] err_count_q, err_count_d;
   logic [CW-1:0] edge_count_q, edge_count_d;

   logic rise, fall, in_range;

   assign rise     = mon & ~mon_q;
   assign fall     = ~mon & mon_q;
   assign in_range = (cnt_q >= MinP) && (cnt_q <= MaxP);

   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      period_d     = period_q;
      period_vld_d = 1'b0;
      high_time_d  = high_time_q;
      err_d        = 1'b0;
      err_cause_d  = err_cause_q;
      err_count_d  = err_count_q;
      edge_count_d = edge_count_q;

      if (rise) begin
         cnt_d = One;
      end else if (cnt_q < MaxP1) begin
         cnt_d = cnt_q + One;
      end else begin
         cnt_d = cnt_q;
      end

      if (rise) begin
         hcnt_d = One;
      end else if (mon && (hcnt_q != '1)) begin
         hcnt_d = hcnt_q + One;
      end else begin
         hcnt_d = hcnt_q;
      end

      if (fall) high_time_d = hcnt_q;
      if (rise) edge_count_d = edge_count_q + One;

      unique case (state_q)
         StIdle: begin
            if (rise) begin
               state_d = StAcq;
               good_d  = '0;
            end
         end
         StAcq, StLock: begin
            if (rise) begin
               period_d     = cnt_q;
               period_vld_d = 1'b1;
               if (!in_range) begin
                  err_d       = 1'b1;
                  err_cause_d = (cnt_q < MinP) ? 2'b01 : 2'b10;
                  good_d      = '0;
                  state_d     = StAcq;
               end else if (state_q == StAcq) begin
                  if (good_q + One == LockN) begin
                     state_d = StLock;
                     good_d  = '0;
                  end else begin
                     good_d = good_q + One;
                  end
               end
            end else if (cnt_q == MaxP) begin
               // rise in this cycle would have been in range, so only time out without one
               err_d       = 1'b1;
               err_cause_d = 2'b11;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (err_d && (err_count_q != '1)) err_count_d = err_count_q + One;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         mon_q        <= 1'b1;  // mon held high through reset is not a rise
         cnt_q        <= '0;
         hcnt_q       <= '0;
         good_q       <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         high_time_q  <= '0;
         err_q        <= 1'b0;
         err_cause_q  <= 2'b00;
         err_count_q  <= '0;
         edge_count_q <= '0;
      end else begin
         state_q      <= state_d;
         mon_q        <= mon;
         cnt_q        <= cnt_d;
         hcnt_q       <= hcnt_d;
         good_q       <= good_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         high_time_q  <= high_time_d;
         err_q        <= err_d;
         err_cause_q  <= err_cause_d;
         err_count_q  <= err_count_d;
         edge_count_q <= edge_count_d;
      end
   end

   assign locked     = (state_q == StLock);
   assign period     = period_q;
   assign period_vld = period_vld_q;
   assign high_time  = high_time_q;
   assign err        = err_q;
   assign err_cause  = err_cause_q;
   assign err_count  = err_count_q;
   assign edge_count = edge_count_q;

endmodule

// File: tb/tb_tb_clkmon.sv
// Randomized bench for tb_clkmon: two instances (default and narrow CW=4) against a
// timestamp-based reference model.
module tb_tb_clkmon;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mon = 1'b0;

   logic        a_locked, a_period_vld, a_err;
   logic [15:0] a_period, a_high_time, a_err_count, a_edge_count;
   logic [1:0]  a_err_cause;
   logic        b_locked, b_period_vld, b_err;
   logic [3:0]  b_period, b_high_time, b_err_count, b_edge_count;
   logic [1:0]  b_err_cause;

   int nvec = 0;
   int nerr = 0;
   bit armed = 0;
   bit rnd_rst = 0;

   always #5 clk = ~clk;

   tb_clkmon dut_a (
      .clk(clk), .reset(reset), .mon(mon), .locked(a_locked), .period(a_period),
      .period_vld(a_period_vld), .high_time(a_high_time), .err(a_err),
      .err_cause(a_err_cause), .err_count(a_err_count), .edge_count(a_edge_count)
   );

   tb_clkmon #(.CW(4), .MIN_PERIOD(3), .MAX_PERIOD(12), .LOCK_EDGES(2)) dut_b (
      .clk(clk), .reset(reset), .mon(mon), .locked(b_locked), .period(b_period),
      .period_vld(b_period_vld), .high_time(b_high_time), .err(b_err),
      .err_cause(b_err_cause), .err_count(b_err_count), .edge_count(b_edge_count)
   );

   // Model tracks timestamps of the last rise / high-phase start rather than counters.
   typedef struct packed {
      int mode;  // 0 idle, 1 acquiring, 2 locked
      int good;
      int last_rise;
      int hstart;
      int cyc;
      int prev;
      int period;
      int vld;
      int high;
      int err;
      int cause;
      int errcnt;
      int edges;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mstep(input mdl_t s_in, input int cw, input int mn, input int mx,
                                  input int lk, input int m, input int rst);
      mdl_t s;
      int lim, age, hage;
      bit rise, fall;
      s   = s_in;
      lim = (1 << cw) - 1;
      if (rst != 0) begin
         s           = '0;
         s.prev      = 1;
         s.cyc       = s_in.cyc + 1;
         s.last_rise = s.cyc;
         s.hstart    = s.cyc;
         return s;
      end
      s.vld = 0;
      s.err = 0;
      rise  = (m != 0) && (s.prev == 0);
      fall  = (m == 0) && (s.prev != 0);
      age   = s.cyc - s.last_rise;
      if (age > mx + 1) age = mx + 1;
      hage = s.cyc - s.hstart;
      if (hage > lim) hage = lim;
      if (fall) s.high = hage;
      if (rise) begin
         s.edges = (s.edges + 1) & lim;
         if (s.mode == 0) begin
            s.mode = 1;
            s.good = 0;
         end else begin
            s.period = age;
            s.vld    = 1;
            if (age < mn || age > mx) begin
               s.err   = 1;
               s.cause = (age < mn) ? 1 : 2;
               s.good  = 0;
               s.mode  = 1;
            end else if (s.mode == 1) begin
               s.good++;
               if (s.good == lk) begin
                  s.mode = 2;
                  s.good = 0;
               end
            end
         end
         s.last_rise = s.cyc;
         s.hstart    = s.cyc;
      end else if (s.mode != 0 && age == mx) begin
         s.err   = 1;
         s.cause = 3;
         s.mode  = 0;
      end
      if (s.err != 0 && s.errcnt < lim) s.errcnt++;
      s.prev = m;
      s.cyc++;
      return s;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic tick(input logic m, input logic r);
      @(negedge clk);
      if (armed) begin
         check_eq("a.locked", 32'(a_locked), 32'(ma.mode == 2));
         check_eq("a.period", 32'(a_period), ma.period);
         check_eq("a.period_vld", 32'(a_period_vld), ma.vld);
         check_eq("a.high_time", 32'(a_high_time), ma.high);
         check_eq("a.err", 32'(a_err), ma.err);
         check_eq("a.err_cause", 32'(a_err_cause), ma.cause);
         check_eq("a.err_count", 32'(a_err_count), ma.errcnt);
         check_eq("a.edge_count", 32'(a_edge_count), ma.edges);
         check_eq("b.locked", 32'(b_locked), 32'(mb.mode == 2));
         check_eq("b.period", 32'(b_period), mb.period);
         check_eq("b.period_vld", 32'(b_period_vld), mb.vld);
         check_eq("b.high_time", 32'(b_high_time), mb.high);
         check_eq("b.err", 32'(b_err), mb.err);
         check_eq("b.err_cause", 32'(b_err_cause), mb.cause);
         check_eq("b.err_count", 32'(b_err_count), mb.errcnt);
         check_eq("b.edge_count", 32'(b_edge_count), mb.edges);
      end
      mon   = m;
      reset = r;
      ma = mstep(ma, 16, 2, 16, 4, int'(m), int'(r));
      mb = mstep(mb, 4, 3, 12, 2, int'(m), int'(r));
      if (r) armed = 1;
   endtask

   task automatic run_period(input int h, input int l);
      for (int i = 0; i < h + l; i++) begin
         tick((i < h), rnd_rst && ($urandom_range(0, 299) == 0));
      end
   endtask

   initial begin
      int h, l, r;
      ma = '0;
      mb = '0;
      repeat (3) tick(1'b0, 1'b1);
      repeat (8) run_period(4, 4);                 // period 8, lock
      repeat (10) run_period(1, 1);                // period 2 (short for narrow instance)
      repeat (6) run_period(8, 8);                 // period 16 boundary
      run_period(8, 9);                            // period 17 -> timeout
      repeat (3) run_period(8, 8);
      repeat (6) run_period(4, 4);
      run_period(40, 4);                           // stuck high
      repeat (6) run_period(4, 4);
      repeat (2) tick(1'b1, 1'b0);                 // reset mid-lock with mon high
      tick(1'b1, 1'b1);
      repeat (2) tick(1'b1, 1'b0);
      repeat (6) run_period(4, 4);
      repeat (20) run_period(1, 1);                // saturate narrow err_count, wrap edges
      rnd_rst = 1;
      h = 4;
      l = 4;
      repeat (1500) begin
         r = int'($urandom_range(0, 99));
         if (r < 15) begin
            h = int'($urandom_range(1, 9));
            l = int'($urandom_range(1, 9));
         end
         if (r == 99) run_period(h, 20);
         else if (r == 98) run_period(30, l);
         else run_period(h, l);
      end
      tick(1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
